// File: rtl/dvbc_pkg.sv
// Shared DVB-C constants and types for the byte/symbol packers.
package dvbc_pkg;

    // Shared with the transmit-side packer.
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SYM_WIDTH = 10;
    localparam int unsigned MODE_W    = 4;

    // Bits per symbol for each constellation.
    localparam logic [MODE_W-1:0] QAM16  = 4'd4;
    localparam logic [MODE_W-1:0] QAM32  = 4'd5;
    localparam logic [MODE_W-1:0] QAM64  = 4'd6;
    localparam logic [MODE_W-1:0] QAM128 = 4'd7;
    localparam logic [MODE_W-1:0] QAM256 = 4'd8;

    // Upstream request FSM.
    typedef enum logic {REQ, WAIT} reqState_e;

    // A mode is usable only for 1..8 bits per symbol.
    function automatic logic isLegalMode(input logic [MODE_W-1:0] mode);
        return (mode != 4'd0) && (mode <= 4'd8);
    endfunction

endpackage

// File: rtl/symbol_to_byte_if.sv
// Symbol-in / byte-out signal bundle of the receive-side repacker.
interface symbol_to_byte_if #(
    parameter int unsigned WIDTH = 10
);
    logic [3:0]       iMode;
    logic [WIDTH-1:0] iSym;
    logic             iValid;
    logic             iPSync;
    logic             oReq;
    logic             iReq;
    logic             oValid;
    logic [7:0]       oData;
    logic             oPSync;
    logic             oErr;

    // Stimulus side: drives symbols, mode and downstream ready.
    modport master (
        output iMode, iSym, iValid, iPSync, iReq,
        input  oReq, oValid, oData, oPSync, oErr
    );

    // Repacker side.
    modport slave (
        input  iMode, iSym, iValid, iPSync, iReq,
        output oReq, oValid, oData, oPSync, oErr
    );
endinterface

// File: rtl/symbol_to_byte.sv
// Pulls m-bit symbols from the demapper and repacks them MSB-first into bytes.
// A packet-start symbol drops any residual bits so byte boundaries realign.
module symbol_to_byte
    import dvbc_pkg::*;
#(
    parameter int unsigned WIDTH = SYM_WIDTH  // must be >= 8
) (
    input  logic              iClk,
    input  logic              iClrn,
    symbol_to_byte_if.slave   bus
);

    localparam int unsigned ACC_W = WIDTH + 7;
    localparam int unsigned CNT_W = $clog2(WIDTH + 8);

    reqState_e          stateQ, stateD;
    logic [ACC_W-1:0]   accQ, accD;
    logic [CNT_W-1:0]   cntQ, cntD;
    logic [3:0]         mregQ, mregD;
    logic               syncQ, syncD;
    logic               reqQ, reqD;
    logic               validQ, validD;
    logic [7:0]         dataQ, dataD;
    logic               psyncQ, psyncD;
    logic               errQ, errD;

    logic               loadMode;
    logic               byteReady;
    logic [3:0]         mEff;
    logic [3:0]         mAcc;
    logic [ACC_W-1:0]   accBase;
    logic [CNT_W-1:0]   cntBase;
    logic [WIDTH-1:0]   symBits;
    logic [ACC_W-1:0]   accShift;

    // Next-state logic for the request FSM and the accumulator datapath.
    always_comb begin
        stateD   = stateQ;
        accD     = accQ;
        cntD     = cntQ;
        mregD    = mregQ;
        syncD    = syncQ;
        reqD     = 1'b0;
        validD   = 1'b0;
        dataD    = dataQ;
        psyncD   = 1'b0;
        errD     = errQ;
        mAcc     = mregQ;
        accBase  = accQ;
        cntBase  = cntQ;

        // Mode is only re-sampled when the pipe is empty and idle, so a
        // mode change never splits bits of one symbol.
        loadMode = (cntQ == '0) && (stateQ == REQ);
        mEff     = loadMode ? bus.iMode : mregQ;
        if (loadMode) begin
            mregD = bus.iMode;
        end

        unique case (stateQ)
            REQ: begin
                if (bus.iValid) begin
                    errD = 1'b1;
                end
                if (!isLegalMode(mEff)) begin
                    errD = 1'b1;
                end else if (cntQ < CNT_W'(8)) begin
                    reqD   = 1'b1;
                    stateD = WAIT;
                end
            end
            WAIT: begin
                if (bus.iValid) begin
                    stateD = REQ;
                    if (bus.iPSync) begin
                        accBase = '0;
                        cntBase = '0;
                        mregD   = bus.iMode;
                        syncD   = 1'b1;
                        // An illegal mode on a sync symbol appends nothing;
                        // the FSM then stalls in REQ with the error raised.
                        if (isLegalMode(bus.iMode)) begin
                            mAcc = bus.iMode;
                        end else begin
                            mAcc = '0;
                            errD = 1'b1;
                        end
                    end
                    accD = (accBase << mAcc) | ACC_W'(symBits);
                    cntD = cntBase + CNT_W'(mAcc);
                end
            end
            default: stateD = REQ;
        endcase

        // Requests only go out while cnt<8, so release never collides with
        // acceptance on the same edge.
        if (byteReady && bus.iReq) begin
            validD = 1'b1;
            dataD  = accShift[7:0];
            cntD   = cntQ - CNT_W'(8);
            psyncD = syncQ;
            syncD  = 1'b0;
        end
    end

    // Significant symbol bits and the byte window at the top of the count.
    always_comb begin
        symBits   = bus.iSym & ~({WIDTH{1'b1}} << mAcc);
        byteReady = (cntQ >= CNT_W'(8));
        accShift  = accQ >> (cntQ - CNT_W'(8));
    end

    // Request FSM state register.
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            stateQ <= REQ;
        end else begin
            stateQ <= stateD;
        end
    end

    // Accumulator, mode, sync flag and registered outputs.
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            accQ   <= '0;
            cntQ   <= '0;
            mregQ  <= '0;
            syncQ  <= 1'b0;
            reqQ   <= 1'b0;
            validQ <= 1'b0;
            dataQ  <= 8'h00;
            psyncQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            accQ   <= accD;
            cntQ   <= cntD;
            mregQ  <= mregD;
            syncQ  <= syncD;
            reqQ   <= reqD;
            validQ <= validD;
            dataQ  <= dataD;
            psyncQ <= psyncD;
            errQ   <= errD;
        end
    end

    assign bus.oReq   = reqQ;
    assign bus.oValid = validQ;
    assign bus.oData  = dataQ;
    assign bus.oPSync = psyncQ;
    assign bus.oErr   = errQ;

endmodule

// File: tb/tb_symbol_to_byte.sv
// Scoreboard bench for symbol_to_byte: expected bytes queued as symbols are
// driven, popped and compared as the DUT releases them.
module tb_symbol_to_byte;
    import dvbc_pkg::*;

    localparam int unsigned W = SYM_WIDTH;

    typedef struct packed {
        logic [7:0] data;
        logic       psync;
    } exp_t;

    logic iClk  = 1'b0;
    logic iClrn = 1'b0;

    exp_t expQ[$];
    exp_t monExp;
    int   assertions = 0;
    int   failures   = 0;
    int   reqCnt     = 0;
    int   reqUsed    = 0;
    int   byteCnt    = 0;

    always #5 iClk = ~iClk;

    symbol_to_byte_if #(.WIDTH(W)) bus ();

    symbol_to_byte #(.WIDTH(W)) dut (
        .iClk  (iClk),
        .iClrn (iClrn),
        .bus   (bus)
    );

    // Output monitor: counts requests and checks released bytes.
    initial begin
        forever begin
            @(negedge iClk);
            if (iClrn) begin
                if (bus.oReq) reqCnt++;
                if (bus.oValid) begin
                    byteCnt++;
                    assertions++;
                    if (expQ.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte: got data=%02h psync=%0b, required none",
                                 bus.oData, bus.oPSync);
                    end else begin
                        monExp = expQ.pop_front();
                        if (bus.oData !== monExp.data) begin
                            failures++;
                            $display("FAIL byte_data: got %02h, required %02h",
                                     bus.oData, monExp.data);
                        end
                        assertions++;
                        if (bus.oPSync !== monExp.psync) begin
                            failures++;
                            $display("FAIL byte_psync: got %0b, required %0b",
                                     bus.oPSync, monExp.psync);
                        end
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic doReset(input logic [3:0] mode, input logic rdy);
        iClrn      = 1'b0;
        bus.iValid = 1'b0;
        bus.iPSync = 1'b0;
        bus.iSym   = '0;
        bus.iMode  = mode;
        bus.iReq   = rdy;
        repeat (3) @(posedge iClk);
        expQ.delete();
        reqUsed = reqCnt;
        @(negedge iClk);
        iClrn = 1'b1;
    endtask

    task automatic sendSym(input logic [W-1:0] sym, input logic ps, input int gap);
        int n = 0;
        while (reqCnt == reqUsed && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (reqCnt == reqUsed) begin
            assertions++;
            failures++;
            $display("FAIL req_timeout: got no oReq in 100 cycles, required one");
        end else begin
            reqUsed++;
            repeat (gap) @(posedge iClk);
            @(posedge iClk);
            #1;
            bus.iSym   = sym;
            bus.iValid = 1'b1;
            bus.iPSync = ps;
            @(posedge iClk);
            #1;
            bus.iValid = 1'b0;
            bus.iPSync = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge iClk);
            n++;
        end
        assertions++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes outstanding, required 0", name, expQ.size());
        end
    endtask

    task automatic checkResetOutputs(input string name);
        assertions++;
        if (bus.oReq !== 1'b0) begin
            failures++; $display("FAIL %s_oReq: got %0b, required 0", name, bus.oReq);
        end
        assertions++;
        if (bus.oValid !== 1'b0) begin
            failures++; $display("FAIL %s_oValid: got %0b, required 0", name, bus.oValid);
        end
        assertions++;
        if (bus.oPSync !== 1'b0) begin
            failures++; $display("FAIL %s_oPSync: got %0b, required 0", name, bus.oPSync);
        end
        assertions++;
        if (bus.oData !== 8'h00) begin
            failures++; $display("FAIL %s_oData: got %02h, required 00", name, bus.oData);
        end
        assertions++;
        if (bus.oErr !== 1'b0) begin
            failures++; $display("FAIL %s_oErr: got %0b, required 0", name, bus.oErr);
        end
    endtask

    task automatic test_reset();
        iClrn      = 1'b0;
        bus.iValid = 1'b0;
        bus.iPSync = 1'b0;
        bus.iSym   = '0;
        bus.iMode  = QAM16;
        bus.iReq   = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        checkResetOutputs("reset");
        @(negedge iClk);
        iClrn = 1'b1;
        @(posedge iClk);
        #1;
        assertions++;
        if (bus.oReq !== 1'b1) begin
            failures++;
            $display("FAIL first_req: got %0b, required 1", bus.oReq);
        end
    endtask

    task automatic test_m4();
        int b0;
        doReset(QAM16, 1'b1);
        b0 = byteCnt;
        expQ.push_back({8'h47, 1'b0});
        sendSym(10'h4, 1'b0, 0);
        sendSym(10'h7, 1'b0, 2);
        waitDrain("m4");
        repeat (5) @(negedge iClk);
        assertions++;
        if (byteCnt - b0 != 1) begin
            failures++;
            $display("FAIL m4_count: got %0d bytes, required 1", byteCnt - b0);
        end
    endtask

    task automatic test_m6();
        int b0;
        doReset(QAM64, 1'b1);
        b0 = byteCnt;
        expQ.push_back({8'h47, 1'b0});
        expQ.push_back({8'h43, 1'b0});
        expQ.push_back({8'h63, 1'b0});
        sendSym(10'h11, 1'b0, 0);
        sendSym(10'h34, 1'b0, 1);
        sendSym(10'h0D, 1'b0, 0);
        sendSym(10'h23, 1'b0, 3);
        waitDrain("m6");
        // Empty residual: the next two symbols form a byte on their own.
        expQ.push_back({8'hAB, 1'b0});
        sendSym(10'h2A, 1'b0, 0);
        sendSym(10'h3F, 1'b0, 0);
        waitDrain("m6_after");
        repeat (5) @(negedge iClk);
        assertions++;
        if (byteCnt - b0 != 4) begin
            failures++;
            $display("FAIL m6_count: got %0d bytes, required 4", byteCnt - b0);
        end
    endtask

    task automatic test_psync();
        doReset(QAM64, 1'b1);
        expQ.push_back({8'h47, 1'b1});
        expQ.push_back({8'h4F, 1'b0});
        sendSym(10'h2A, 1'b0, 0);
        sendSym(10'h11, 1'b1, 0);
        sendSym(10'h34, 1'b0, 1);
        sendSym(10'h3F, 1'b0, 0);
        waitDrain("psync");
    endtask

    task automatic test_hold();
        int b0;
        doReset(QAM256, 1'b0);
        b0 = byteCnt;
        sendSym(10'hB8, 1'b0, 0);
        repeat (10) @(negedge iClk);
        assertions++;
        if (byteCnt != b0) begin
            failures++;
            $display("FAIL hold_no_valid: got %0d bytes, required 0", byteCnt - b0);
        end
        assertions++;
        if (reqCnt != reqUsed) begin
            failures++;
            $display("FAIL hold_no_req: got %0d extra requests, required 0", reqCnt - reqUsed);
        end
        assertions++;
        if (bus.oErr !== 1'b0) begin
            failures++;
            $display("FAIL hold_err_clear: got %0b, required 0", bus.oErr);
        end
        // Unsolicited symbol while the byte is held.
        @(posedge iClk);
        #1;
        bus.iSym   = 10'h3FF;
        bus.iValid = 1'b1;
        bus.iPSync = 1'b1;
        @(posedge iClk);
        #1;
        bus.iValid = 1'b0;
        bus.iPSync = 1'b0;
        @(negedge iClk);
        assertions++;
        if (bus.oErr !== 1'b1) begin
            failures++;
            $display("FAIL unsolicited_err: got %0b, required 1", bus.oErr);
        end
        expQ.push_back({8'hB8, 1'b0});
        bus.iReq = 1'b1;
        @(negedge iClk);
        assertions++;
        if (bus.oValid !== 1'b1 || bus.oData !== 8'hB8) begin
            failures++;
            $display("FAIL release: got valid=%0b data=%02h, required valid=1 data=b8",
                     bus.oValid, bus.oData);
        end
        assertions++;
        if (bus.oReq !== 1'b0) begin
            failures++;
            $display("FAIL release_req_early: got %0b, required 0", bus.oReq);
        end
        @(negedge iClk);
        assertions++;
        if (bus.oReq !== 1'b1) begin
            failures++;
            $display("FAIL release_req: got %0b, required 1", bus.oReq);
        end
        expQ.push_back({8'h5A, 1'b0});
        sendSym(10'h5A, 1'b0, 0);
        waitDrain("hold");
        assertions++;
        if (bus.oErr !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %0b, required 1", bus.oErr);
        end
    endtask

    task automatic test_bad_mode();
        int r0;
        int n;
        doReset(4'd0, 1'b1);
        r0 = reqCnt;
        repeat (10) @(negedge iClk);
        assertions++;
        if (reqCnt != r0) begin
            failures++;
            $display("FAIL bad_mode_req: got %0d requests, required 0", reqCnt - r0);
        end
        assertions++;
        if (bus.oErr !== 1'b1) begin
            failures++;
            $display("FAIL bad_mode_err: got %0b, required 1", bus.oErr);
        end
        // A legal mode restarts requests; reset lands just after the byte.
        bus.iMode = QAM16;
        expQ.push_back({8'h47, 1'b0});
        sendSym(10'h4, 1'b0, 0);
        sendSym(10'h7, 1'b0, 0);
        n = 0;
        while (!bus.oValid && n < 20) begin
            @(negedge iClk);
            n++;
        end
        assertions++;
        if (!bus.oValid) begin
            failures++;
            $display("FAIL midstream_valid: got no oValid in 20 cycles, required one");
        end
        #2;
        iClrn = 1'b0;
        #1;
        checkResetOutputs("midstream");
        // Symbol strobed during reset must be lost.
        bus.iSym   = 10'h3;
        bus.iValid = 1'b1;
        @(posedge iClk);
        #1;
        bus.iValid = 1'b0;
        @(posedge iClk);
        expQ.delete();
        reqUsed = reqCnt;
        @(negedge iClk);
        iClrn = 1'b1;
        expQ.push_back({8'h47, 1'b0});
        sendSym(10'h4, 1'b0, 0);
        sendSym(10'h7, 1'b0, 0);
        waitDrain("after_reset");
    endtask

    initial begin
        bus.iMode  = QAM16;
        bus.iSym   = '0;
        bus.iValid = 1'b0;
        bus.iPSync = 1'b0;
        bus.iReq   = 1'b1;
        test_reset();
        test_m4();
        test_m6();
        test_psync();
        test_hold();
        test_bad_mode();
        repeat (3) @(negedge iClk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/symbol_to_byte.md
# symbol_to_byte

Receive-side inverse of the transmit byte-to-symbol packer in the DVB-C chain. Sits between the QAM demapper and the MPEG-TS byte path. It pulls m-bit symbols from upstream through a request/valid handshake and repacks them MSB-first into bytes. Bytes are released to downstream under a ready level. Packet-start marks on input symbols realign byte boundaries.

## Interface
- WIDTH, 10: symbol bus width. This is the maximum bits per symbol. Must be ≥ 8.
- iClk  in  1  clock, rising edge.
- iClrn  in  1  reset, asynchronous, active-low.
- iMode  in  4  bits per symbol m. Legal range is 1..8; 4..8 cover 16- to 256-QAM.
- iSym  in  WIDTH  symbol. Bits [m-1:0] are significant; [m-1] is the earliest bit.
- iValid  in  1  one-cycle strobe, iSym valid.
- iPSync  in  1  qualifies iValid: the symbol is the first of a packet.
- oReq  out  1  one-cycle pulse requesting one symbol from upstream.
- iReq  in  1  downstream ready level.
- oValid  out  1  one-cycle strobe, oData valid.
- oData  out  8  byte, MSB is the earliest bit.
- oPSync  out  1  qualifies oValid: first byte after a packet-start symbol.
- oErr  out  1  sticky error flag.

## Operation
- Accumulator acc is WIDTH+7 bits wide. The bit count cnt ranges 0..WIDTH+7.
- Mode register mreg is loaded from iMode in two cases:
  - when cnt==0 and no request is outstanding;
  - on every accepted iPSync symbol.
- If iMode is 0 or >8, the block issues no requests and sets oErr.
- Request FSM, two states:
  - REQ: when cnt<8 and mreg is legal, drive oReq=1 for one cycle, then go to WAIT.
  - WAIT: on iValid, accept the symbol and return to REQ.
- At most one request is outstanding.
- Accepting a symbol appends the m bits at the LSB side: acc←(acc<<m)|iSym[m-1:0], cnt←cnt+m.
- Accepting a symbol with iPSync=1:
  - residual bits are discarded first (cnt←0, acc←0), then the symbol is appended;
  - the sync-pending flag is set.
- Byte release: when cnt≥8 and iReq=1 on a clock edge:
  - oData←acc[cnt-1 -: 8], oValid←1, cnt←cnt-8;
  - oPSync←sync-pending, and sync-pending is cleared.
- Otherwise oValid=0 and oPSync=0. oData holds its last value.
- Requests are made only when cnt<8, so a symbol never arrives while a byte is pending. Acceptance and release never occur on the same edge, and acc cannot overflow.
- An unsolicited iValid (state REQ) is ignored and sets oErr. iPSync without iValid is ignored.
- oErr clears only on reset.

## Timing
- Reset values: oReq=0, oValid=0, oPSync=0, oData=0x00, oErr=0. Internal state: cnt=0, acc=0, state=REQ, sync-pending=0.
- First oReq is high in the cycle after the first rising edge following iClrn release.
- iValid may arrive any number of cycles ≥1 after oReq.
- The next oReq is issued no earlier than 1 cycle after acceptance, and only if cnt<8.
- Latency: a symbol completing a byte is sampled at edge t. With iReq=1, oValid is high after edge t+1.
- While iReq=0 and cnt≥8:
  - the byte is held and no oReq is issued;
  - oValid stays low.
- A symbol of m=8 at cnt=0 gives exactly one byte and cnt=0.
- Reset asserted mid-operation:
  - all state clears immediately;
  - any outstanding request is forgotten;
  - an iValid during reset is lost.

## Structure
- Package dvbc_pkg holds:
  - mode constants QAM16=4, QAM32=5, QAM64=6, QAM128=7, QAM256=8;
  - the request FSM enum {REQ, WAIT};
  - the legal-mode check function.
- The byte and WIDTH constants are shared with the transmit-side packer.
- Single module, no sub-modules.

## Test plan
- m=4, iReq=1; symbols 0x4 then 0x7 → one oValid, oData=0x47, oPSync=0.
- m=6, iReq=1; symbols 0x11, 0x34, 0x0D, 0x23 (24 bits) → bytes 0x47, 0x43, 0x63 in order, then cnt=0.
- m=6; first symbol 0x2A, then an iPSync symbol 0x11 followed by 0x34 → residual 6 bits dropped, first byte 0x47 with oPSync=1.
- m=8, iReq held low for 10 cycles after symbol 0xB8 → no oValid and no new oReq. On iReq rise: oValid with 0xB8 on the next edge, then oReq.
- iValid pulsed with no request outstanding → oErr=1 stays until reset; cnt unchanged.
- iMode=0 out of reset → no oReq and oErr=1. Assert iClrn low mid-stream → all outputs at reset values within the reset cycle.
